// File: rtl/fnd_scan_controller_if.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller_if
//
// Bundles the display data inputs and the scanned display outputs of
// fnd_scan_controller. The clock and reset are kept as plain module ports.
//
// Parameter
//   DIGITS           number of scanned digits (1..8)
//
// Signals
//   i_en             display enable; low blanks the display and freezes the scan
//   i_value          packed nibbles, digit k = i_value[4k+3:4k], digit 0 rightmost
//   i_dp             decimal point request per digit, 1 = lit
//   i_blank          force a digit dark (segments and dp), 1 = blank
//   o_Digit          anode select, active-low one-hot, all ones = all off
//   o_Seg            segments, active-low, [7]=dp, [6:0]=g,f,e,d,c,b,a
//   o_digitPosition  index of the digit currently driven
//
// Modports
//   master           data source (drives i_*, observes o_*)
//   slave            the scan controller (consumes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface fnd_scan_controller_if #(
   parameter int DIGITS = 4
);
   logic                  i_en;
   logic [4*DIGITS-1:0]   i_value;
   logic [DIGITS-1:0]     i_dp;
   logic [DIGITS-1:0]     i_blank;
   logic [DIGITS-1:0]     o_Digit;
   logic [7:0]            o_Seg;
   logic [2:0]            o_digitPosition;

   modport master (
      output i_en,
      output i_value,
      output i_dp,
      output i_blank,
      input  o_Digit,
      input  o_Seg,
      input  o_digitPosition
   );

   modport slave (
      input  i_en,
      input  i_value,
      input  i_dp,
      input  i_blank,
      output o_Digit,
      output o_Seg,
      output o_digitPosition
   );
endinterface

// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
//
// Multiplexed common-anode 7-segment display driver. Scans DIGITS digits, each
// for CLK_DIV clock cycles, from a packed hex value. Inputs are snapshotted once
// per frame (on the tick that returns the scan to digit 0) so a frame never
// shows a mix of old and new values. All outputs are registered.
//
// Parameters
//   DIGITS    number of scanned digits, 1..8
//   CLK_DIV   clock cycles per digit slot, >= 2
//
// Ports
//   i_clk     system clock, rising edge
//   i_reset   asynchronous, active-high reset
//   bus       fnd_scan_controller_if.slave
//               i_en, i_value, i_dp, i_blank  (inputs)
//               o_Digit, o_Seg, o_digitPosition (outputs)
//
// Build option
//   FND_LZB_EN  when defined, leading-zero blanking is compiled in: digit k
//               (k >= 1) has segments a..g turned off when its nibble and all
//               higher nibbles are zero. Digit 0 is never zero-blanked and the
//               decimal point is unaffected. When undefined, every digit shows
//               its nibble and no blanking logic exists.
// -----------------------------------------------------------------------------
module fnd_scan_controller #(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   fnd_scan_controller_if.slave  bus
);

   localparam int              CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [2:0]      POS_LAST = 3'(DIGITS - 1);

   // The display stays dark after reset until the first prescaler tick has
   // selected digit 0 and taken the first snapshot.
   typedef enum logic {
      ST_DARK = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t               state_reg;
   state_t               state_next;

   logic [CNT_W-1:0]     cnt_reg;
   logic [CNT_W-1:0]     cnt_next;
   logic [2:0]           pos_reg;
   logic [2:0]           pos_next;

   logic [4*DIGITS-1:0]  snap_value_reg;
   logic [DIGITS-1:0]    snap_dp_reg;
   logic [DIGITS-1:0]    snap_blank_reg;

   logic [DIGITS-1:0]    digit_reg;
   logic [DIGITS-1:0]    digit_next;
   logic [7:0]           seg_reg;
   logic [7:0]           seg_next;

   logic                 tick;
   logic                 snap_take;

   // Values the next registered output is built from: the fresh inputs on the
   // edge that takes the snapshot, otherwise the held snapshot.
   logic [4*DIGITS-1:0]  view_value;
   logic [DIGITS-1:0]    view_dp;
   logic [DIGITS-1:0]    view_blank;

   logic [6:0]           glyph [DIGITS];
   logic [6:0]           sel_glyph;
   logic                 sel_dp;
   logic                 sel_blank;
`ifdef FND_LZB_EN
   logic                 lz_blank [DIGITS];
   logic                 sel_lzb;
`endif

   // Hex nibble to active-low segments g..a.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Tick is qualified by i_en so a disable on the terminal count freezes the
   // scan without advancing or snapshotting.
   assign tick      = bus.i_en && (cnt_reg == CNT_LAST);
   assign snap_take = tick && (pos_reg == POS_LAST);

   assign view_value = snap_take ? bus.i_value : snap_value_reg;
   assign view_dp    = snap_take ? bus.i_dp    : snap_dp_reg;
   assign view_blank = snap_take ? bus.i_blank : snap_blank_reg;

   // Per-digit glyphs and optional leading-zero flags.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign glyph[gi] = hex_glyph(view_value[4*gi +: 4]);
`ifdef FND_LZB_EN
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            assign lz_blank[gi] = (view_value[4*DIGITS-1 : 4*gi] == '0);
         end
`endif
      end
   endgenerate

   // Next-state, prescaler/position and output decode.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pos_next   = pos_reg;
      digit_next = '1;
      seg_next   = 8'hFF;
      sel_glyph  = 7'h7F;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
`ifdef FND_LZB_EN
      sel_lzb    = 1'b0;
`endif

      if (bus.i_en) begin
         cnt_next = tick ? '0 : cnt_reg + 1'b1;
      end
      if (tick) begin
         pos_next = (pos_reg == POS_LAST) ? 3'd0 : pos_reg + 3'd1;
      end

      case (state_reg)
         ST_DARK: if (tick) state_next = ST_SCAN;
         ST_SCAN: state_next = ST_SCAN;
      endcase

      // Mux the digit that will be driven after this edge.
      for (int k = 0; k < DIGITS; k++) begin
         if (pos_next == 3'(k)) begin
            sel_glyph = glyph[k];
            sel_dp    = view_dp[k];
            sel_blank = view_blank[k];
`ifdef FND_LZB_EN
            sel_lzb   = lz_blank[k];
`endif
         end
      end

      if (bus.i_en && (state_next == ST_SCAN)) begin
         for (int k = 0; k < DIGITS; k++) begin
            digit_next[k] = (pos_next != 3'(k));
         end
         // A blanked digit keeps its anode so every digit has the same duty.
         if (sel_blank) begin
            seg_next = 8'hFF;
         end else begin
`ifdef FND_LZB_EN
            seg_next = {~sel_dp, sel_lzb ? 7'h7F : sel_glyph};
`else
            seg_next = {~sel_dp, sel_glyph};
`endif
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg      <= ST_DARK;
         cnt_reg        <= '0;
         pos_reg        <= POS_LAST;
         snap_value_reg <= '0;
         snap_dp_reg    <= '0;
         snap_blank_reg <= '0;
         digit_reg      <= '1;
         seg_reg        <= 8'hFF;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pos_reg   <= pos_next;
         digit_reg <= digit_next;
         seg_reg   <= seg_next;
         if (snap_take) begin
            snap_value_reg <= bus.i_value;
            snap_dp_reg    <= bus.i_dp;
            snap_blank_reg <= bus.i_blank;
         end
      end
   end

   assign bus.o_Digit         = digit_reg;
   assign bus.o_Seg           = seg_reg;
   assign bus.o_digitPosition = pos_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_controller
//
// Self-checking bench for fnd_scan_controller with DIGITS=4, CLK_DIV=4.
// Each scenario pushes the expected display slots (anode, segments, position,
// duration in cycles) into a queue while it drives the inputs, then pops them
// and compares the outputs on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_fnd_scan_controller;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
`ifdef FND_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct {
      logic [3:0] digit;
      logic [7:0] seg;
      logic [2:0] pos;
      int         cycles;
      string      tag;
   } slot_t;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   slot_t sb [$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   fnd_scan_controller_if #(.DIGITS(DIGITS)) bus ();

   fnd_scan_controller #(
      .DIGITS  (DIGITS),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Reference glyph table, dp off.
   function automatic logic [7:0] glyph(input logic [3:0] n);
      logic [7:0] t [16];
      t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[n];
   endfunction

   task automatic push_dark(input logic [2:0] pos, input int cycles, input string tag);
      slot_t s;
      s.digit = 4'b1111; s.seg = 8'hFF; s.pos = pos; s.cycles = cycles; s.tag = tag;
      sb.push_back(s);
   endtask

   task automatic push_digit(input int k, input logic [7:0] seg, input int cycles, input string tag);
      slot_t s;
      s.digit    = 4'b1111;
      s.digit[k] = 1'b0;
      s.seg = seg; s.pos = 3'(k); s.cycles = cycles; s.tag = tag;
      sb.push_back(s);
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      slot_t s;
      bus.i_en = 1'b1; bus.i_value = 16'h1234; bus.i_dp = '0; bus.i_blank = '0;
      rst = 1'b1;
      #2;
      n_cmp++;
      if (bus.o_Digit !== 4'b1111 || bus.o_Seg !== 8'hFF || bus.o_digitPosition !== 3'd3) begin
         n_bad++;
         $display("FAIL reset_async: got digit=%b seg=%h pos=%0d, want 1111/ff/3",
                  bus.o_Digit, bus.o_Seg, bus.o_digitPosition);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.o_Digit !== 4'b1111 || bus.o_Seg !== 8'hFF || bus.o_digitPosition !== 3'd3) begin
         n_bad++;
         $display("FAIL reset_held: got digit=%b seg=%h pos=%0d, want 1111/ff/3",
                  bus.o_Digit, bus.o_Seg, bus.o_digitPosition);
      end
      rst = 1'b0;
      push_dark(3'd3, CLK_DIV - 1, "pre_tick");
      push_digit(0, 8'h99, CLK_DIV, "1234_d0");
      push_digit(1, 8'hB0, CLK_DIV, "1234_d1");
      push_digit(2, 8'hA4, CLK_DIV, "1234_d2");
      push_digit(3, 8'hF9, CLK_DIV, "1234_d3");
      push_digit(0, 8'h99, CLK_DIV, "1234_d0b");
      push_digit(1, 8'hB0, CLK_DIV, "1234_d1b");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   // Value changes while digit 1 is on; rest of the frame keeps the old value.
   task automatic test_midframe();
      slot_t s;
      bus.i_value = 16'hABCD;
      push_digit(2, glyph(4'h2), CLK_DIV, "old_d2");
      push_digit(3, glyph(4'h1), CLK_DIV, "old_d3");
      push_digit(0, 8'hA1, CLK_DIV, "abcd_d0");
      push_digit(1, 8'hC6, CLK_DIV, "abcd_d1");
      push_digit(2, 8'h83, CLK_DIV, "abcd_d2");
      push_digit(3, 8'h88, CLK_DIV, "abcd_d3");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_dp_blank();
      slot_t s;
      bus.i_value = 16'h0008; bus.i_dp = 4'b0100; bus.i_blank = 4'b1000;
      push_digit(0, 8'h80, CLK_DIV, "dpb_d0");
      push_digit(1, LZB ? 8'hFF : 8'hC0, CLK_DIV, "dpb_d1");
      push_digit(2, LZB ? 8'h7F : 8'h40, CLK_DIV, "dpb_d2_dp");
      push_digit(3, 8'hFF, CLK_DIV, "dpb_d3_blank");
      push_digit(0, 8'h80, 2, "dpb_d0_half");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   // Disable for 10 cycles mid-slot; the slot then finishes its remaining 2.
   task automatic test_enable();
      slot_t s;
      bus.i_en = 1'b0;
      push_dark(3'd0, 10, "en_off");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
      bus.i_en = 1'b1;
      push_digit(0, 8'h80, 2, "en_resume_d0");
      push_digit(1, LZB ? 8'hFF : 8'hC0, CLK_DIV, "en_d1");
      push_digit(2, LZB ? 8'h7F : 8'h40, 2, "en_d2_half");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reset while digit 2 is lit, then a full restart from the dark state.
   task automatic test_reset_midframe();
      slot_t s;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_Digit !== 4'b1111 || bus.o_Seg !== 8'hFF || bus.o_digitPosition !== 3'd3) begin
         n_bad++;
         $display("FAIL reset_midframe: got digit=%b seg=%h pos=%0d, want 1111/ff/3",
                  bus.o_Digit, bus.o_Seg, bus.o_digitPosition);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_dark(3'd3, CLK_DIV - 1, "rst_dark");
      push_digit(0, 8'h80, CLK_DIV, "rst_d0");
      push_digit(1, LZB ? 8'hFF : 8'hC0, CLK_DIV, "rst_d1");
      push_digit(2, LZB ? 8'h7F : 8'h40, CLK_DIV, "rst_d2");
      push_digit(3, 8'hFF, CLK_DIV, "rst_d3");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_leading_zero();
      slot_t s;
      bus.i_value = 16'h0050; bus.i_dp = '0; bus.i_blank = '0;
      push_digit(0, 8'hC0, CLK_DIV, "lz_d0");
      push_digit(1, 8'h92, CLK_DIV, "lz_d1");
      push_digit(2, LZB ? 8'hFF : 8'hC0, CLK_DIV, "lz_d2");
      push_digit(3, LZB ? 8'hFF : 8'hC0, CLK_DIV, "lz_d3");
      push_digit(0, 8'hC0, CLK_DIV, "lz_d0b");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   // Disable exactly on the terminal count: the tick must not advance.
   task automatic test_en_on_tick();
      slot_t s;
      bus.i_en = 1'b0;
      push_dark(3'd0, 1, "tick_off");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
      bus.i_en = 1'b1;
      push_digit(1, 8'h92, CLK_DIV, "tick_d1");
      push_digit(2, LZB ? 8'hFF : 8'hC0, CLK_DIV, "tick_d2");
      while (sb.size() != 0) begin
         s = sb.pop_front();
         for (int c = 0; c < s.cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_Digit !== s.digit || bus.o_Seg !== s.seg || bus.o_digitPosition !== s.pos) begin
               n_bad++;
               $display("FAIL %s[%0d]: got digit=%b seg=%h pos=%0d, want digit=%b seg=%h pos=%0d",
                        s.tag, c, bus.o_Digit, bus.o_Seg, bus.o_digitPosition, s.digit, s.seg, s.pos);
            end
         end
         $display("slot %s digit=%b seg=%h pos=%0d cycles=%0d", s.tag, s.digit, s.seg, s.pos, s.cycles);
      end
   endtask

   // --------------------------------------------------------------------------
   initial begin
      bus.i_en    = 1'b0;
      bus.i_value = '0;
      bus.i_dp    = '0;
      bus.i_blank = '0;
      test_reset();
      test_midframe();
      test_dp_blank();
      test_enable();
      test_reset_midframe();
      test_leading_zero();
      test_en_on_tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Multiplexed 7-segment (FND) display driver for the Basys3 fan-control design and later boards. It time-multiplexes DIGITS common-anode digits from a packed hex/BCD value, with an internal scan prescaler, per-digit decimal point and blank masks, and frame-coherent input snapshotting. It replaces the fixed 4-digit position decoder plus external scan counter: position counting, anode decoding and segment encoding all live here.

## Interface
- DIGITS, 4, number of digits scanned; legal 1..8
- CLK_DIV, 100000, i_clk cycles per digit slot; legal >= 2 (100 MHz -> 1 kHz per digit)
- i_clk  input  1  system clock, rising edge
- i_reset  input  1  reset, asynchronous, active-high
- i_en  input  1  display enable; low blanks all outputs and freezes scanning
- i_value  input  4*DIGITS  digit k nibble = i_value[4k+3:4k]; digit 0 is rightmost
- i_dp  input  DIGITS  decimal point request per digit, 1 = lit
- i_blank  input  DIGITS  force digit off (segments and dp), 1 = blank
- o_Digit  output  DIGITS  anode select, active-low one-hot; all ones = all off
- o_Seg  output  8  segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
- o_digitPosition  output  3  index of the digit currently driven, zero-extended

## Operation
- Prescaler r_cnt counts 0..CLK_DIV-1 while i_en=1; tick = (r_cnt == CLK_DIV-1) && i_en.
- On a tick edge: r_cnt <= 0; position advances pos <= (pos == DIGITS-1) ? 0 : pos+1.
- Snapshot: on the tick edge where the next position is 0, i_value, i_dp, i_blank are latched into snapshot registers. Digits 1..DIGITS-1 of that frame are displayed from the snapshot; digit 0 is displayed from the same values (loaded on the same edge). Mid-frame input changes never appear until the next frame.
- Anode: o_Digit = ~(1 << pos) when enabled.
- Segment encode, hex 0..F, shown as o_Seg with dp off: 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90, A=0x88, b=0x83, C=0xC6, d=0xA1, E=0x86, F=0x8E.
- dp: o_Seg[7] = ~snap_dp[pos].
- Blank: snap_blank[pos]=1 -> o_Seg = 0xFF; o_Digit still selects the digit (constant scan duty).
- i_en=0: o_Digit and o_Seg forced to all ones on the next edge; r_cnt, pos and snapshot hold. On i_en returning to 1 the scan resumes from the held r_cnt and pos.

## Timing
- Reset values: r_cnt=0, pos=DIGITS-1, o_digitPosition=DIGITS-1, o_Digit=all ones, o_Seg=0xFF, snapshot registers=0.
- First tick occurs CLK_DIV edges after reset release; on it pos=0, snapshot taken, digit 0 lit with its glyph. Every output is registered and changes only on that tick edge (or the edge after an i_en change).
- Each digit is driven for exactly CLK_DIV cycles; full frame = DIGITS*CLK_DIV cycles.
- Latency input -> display: new i_value becomes visible on the first frame-start tick after it is applied; worst case DIGITS*CLK_DIV cycles.
- DIGITS=1: pos stays 0; snapshot every tick.
- Reset asserted mid-frame: all registers return to reset values immediately (asynchronous); outputs dark until the first tick after release.
- i_en deasserted on the same edge as a tick: tick is suppressed (tick qualified by i_en); no advance, no snapshot.

## Configuration
- FND_LZB_EN: leading-zero blanking compiled in.
  - Defined: digit k (k >= 1) is blanked (segments a..g off) when its snapshot nibble and every higher nibble are zero; digit 0 is never blanked; dp still follows snap_dp[k] unless i_blank forces it off.
  - Undefined: all digits show their nibble, zeros included; no extra logic.

## Test plan
- DIGITS=4, CLK_DIV=4, reset then i_en=1, i_value=16'h1234, i_dp=0, i_blank=0 -> after 4 cycles o_Digit=1110/o_Seg=0x99, then every 4 cycles 1101/0xB0, 1011/0xA4, 0111/0xF9, repeating.
- i_value changed 16'h1234 -> 16'hABCD while pos=1 -> digits 2,3 still show 2,1; next frame shows D=0xA1, C=0xC6, B=0x83, A=0x88.
- i_dp=4'b0100, i_blank=4'b1000, i_value=16'h0008 -> digit0 0x80, digit2 0x40 (dp lit), digit3 o_Seg=0xFF with o_Digit=0111.
- i_en low for 10 cycles mid-slot -> o_Digit=1111, o_Seg=0xFF, o_digitPosition frozen; on re-enable scan resumes with remaining slot length unchanged.
- Reset asserted at pos=2 -> same cycle o_Digit=1111, o_Seg=0xFF, o_digitPosition=3; first lit digit is digit 0 CLK_DIV cycles after release.
- With FND_LZB_EN, i_value=16'h0050 -> digits 3,2 0xFF, digit1 0x92, digit0 0xC0; without it digits 3,2 show 0xC0.
